// File: rtl/hist_ram_ctrl_if.sv
// Control, sample, readout-stream and RAM-port signals of hist_ram_ctrl.
// master = controller side, slave = surrounding logic (front-end, consumer, RAM).
interface hist_ram_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              start_clear;
  logic              start_acq;
  logic              stop_acq;
  logic              start_read;
  logic [31:0]       num_samples;
  logic              sample_valid;
  logic [ADDR_W-1:0] sample_code;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [WIDTH-1:0]  ram_din_a;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [WIDTH-1:0]  ram_dout_b;

  modport master (
    input  start_clear, start_acq, stop_acq, start_read, num_samples,
    input  sample_valid, sample_code, rd_ready, ram_dout_b,
    output rd_valid, rd_addr, rd_data, busy, done,
    output ram_wen, ram_addr_a, ram_din_a, ram_addr_b
  );

  modport slave (
    output start_clear, start_acq, stop_acq, start_read, num_samples,
    output sample_valid, sample_code, rd_ready, ram_dout_b,
    input  rd_valid, rd_addr, rd_data, busy, done,
    input  ram_wen, ram_addr_a, ram_din_a, ram_addr_b
  );
endinterface

// File: rtl/hist_ram_ctrl.sv
// Histogram RAM sequencer: CLEAR, ACQUIRE (2-stage read-modify-write, 1 sample/cycle), READOUT via 2-entry skid buffer.
// HIST_SATURATE_EN selects a saturating bin increment; otherwise bins wrap modulo 2^WIDTH.
module hist_ram_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  hist_ram_ctrl_if.master bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACQ   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  logic [2:0]        state;
  logic              done_q;
  logic [ADDR_W-1:0] clr_addr;
  logic [31:0]       acc_cnt;
  logic [31:0]       num_lat;

  logic              s2_vld;
  logic [ADDR_W-1:0] s2_code;
  logic              byp_vld;
  logic [ADDR_W-1:0] byp_addr;
  logic [WIDTH-1:0]  byp_dat;

  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_all;
  logic              fl_vld;
  logic [ADDR_W-1:0] fl_addr;
  logic [1:0]        occ;
  logic [WIDTH-1:0]  b0_dat, b1_dat;
  logic [ADDR_W-1:0] b0_addr, b1_addr;

  logic              accept;
  logic              acq_end;
  logic              pop;
  logic              issue;
  logic [WIDTH-1:0]  old_val;
  logic [WIDTH-1:0]  new_val;

  always_comb begin
    accept  = (state == S_ACQ) && bus.sample_valid && !bus.stop_acq;
    acq_end = (state == S_ACQ) &&
              (bus.stop_acq || (accept && num_lat != 32'd0 && acc_cnt + 32'd1 == num_lat));

    // The RAM returns pre-write data when the previous cycle wrote this same bin.
    old_val = (byp_vld && byp_addr == s2_code) ? byp_dat : bus.ram_dout_b;
`ifdef HIST_SATURATE_EN
    new_val = (&old_val) ? old_val : old_val + WIDTH'(1);
`else
    new_val = old_val + WIDTH'(1);
`endif

    pop   = (occ != 2'd0) && bus.rd_ready;
    issue = (state == S_READ) && !rd_all &&
            ((occ - {1'b0, pop} + {1'b0, fl_vld}) < 2'd2);

    bus.busy       = (state != S_IDLE);
    bus.done       = done_q;
    bus.rd_valid   = (occ != 2'd0);
    bus.rd_data    = b0_dat;
    bus.rd_addr    = b0_addr;
    bus.ram_wen    = 1'b0;
    bus.ram_addr_a = '0;
    bus.ram_din_a  = '0;
    bus.ram_addr_b = '0;

    case (state)
      S_CLEAR: begin
        bus.ram_wen    = 1'b1;
        bus.ram_addr_a = clr_addr;
      end
      S_ACQ, S_DRAIN: begin
        if (s2_vld) begin
          bus.ram_wen    = 1'b1;
          bus.ram_addr_a = s2_code;
          bus.ram_din_a  = new_val;
        end
        if (accept) bus.ram_addr_b = bus.sample_code;
      end
      S_READ: bus.ram_addr_b = rd_ptr;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      done_q   <= 1'b0;
      clr_addr <= '0;
      acc_cnt  <= '0;
      num_lat  <= '0;
      s2_vld   <= 1'b0;
      s2_code  <= '0;
      byp_vld  <= 1'b0;
      byp_addr <= '0;
      byp_dat  <= '0;
      rd_ptr   <= '0;
      rd_all   <= 1'b0;
      fl_vld   <= 1'b0;
      fl_addr  <= '0;
      occ      <= '0;
      b0_dat   <= '0;
      b1_dat   <= '0;
      b0_addr  <= '0;
      b1_addr  <= '0;
    end else begin
      done_q   <= 1'b0;
      s2_vld   <= accept;
      s2_code  <= bus.sample_code;
      byp_vld  <= s2_vld;
      byp_addr <= s2_code;
      byp_dat  <= new_val;
      fl_vld   <= issue;
      fl_addr  <= rd_ptr;

      case (state)
        S_IDLE: begin
          clr_addr <= '0;
          acc_cnt  <= '0;
          rd_ptr   <= '0;
          rd_all   <= 1'b0;
          if (bus.start_clear) begin
            state <= S_CLEAR;
          end else if (bus.start_acq) begin
            state   <= S_ACQ;
            num_lat <= bus.num_samples;
          end else if (bus.start_read) begin
            state <= S_READ;
          end
        end
        S_CLEAR: begin
          if (clr_addr == LAST) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        S_ACQ: begin
          if (accept) acc_cnt <= acc_cnt + 32'd1;
          if (acq_end) state <= S_DRAIN;
        end
        S_DRAIN: begin
          state  <= S_IDLE;
          done_q <= 1'b1;
        end
        S_READ: begin
          if (issue) begin
            if (rd_ptr == LAST) rd_all <= 1'b1;
            else                rd_ptr <= rd_ptr + ADDR_W'(1);
          end
          if (pop && b0_addr == LAST) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Skid buffer: b0 is the presented head; it only moves on a pop.
      case ({fl_vld, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            b0_dat  <= bus.ram_dout_b;
            b0_addr <= fl_addr;
          end else begin
            b1_dat  <= bus.ram_dout_b;
            b1_addr <= fl_addr;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          b0_dat  <= b1_dat;
          b0_addr <= b1_addr;
          occ     <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            b0_dat  <= bus.ram_dout_b;
            b0_addr <= fl_addr;
          end else begin
            b0_dat  <= b1_dat;
            b0_addr <= b1_addr;
            b1_dat  <= bus.ram_dout_b;
            b1_addr <= fl_addr;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hist_ram_ctrl.sv
// Bench for hist_ram_ctrl: bin-count model driven by the stimulus, a read-before-write RAM model, per-cycle compare process.
module tb_hist_ram_ctrl;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int MAXV   = (1 << WIDTH) - 1;
  localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_ACQ = 2, PH_READ = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hist_ram_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  hist_ram_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int exp_bin [DEPTH];
  int ph = PH_IDLE;
  bit scramble = 1'b1;
  bit qv [$];
  int qc [$];

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  function automatic int incb(input int x);
`ifdef HIST_SATURATE_EN
    return (x == MAXV) ? x : x + 1;
`else
    return (x + 1) % (MAXV + 1);
`endif
  endfunction

  // RAM: synchronous read, 1-cycle latency, old data on same-address collision.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'($urandom);
    end else if (bus.ram_wen) begin
      mem[bus.ram_addr_a] <= bus.ram_din_a;
    end
    bus.ram_dout_b <= mem[bus.ram_addr_b];
  end

  int done_cnt = 0;
  always @(posedge clk) if (rst_n && bus.done) done_cnt <= done_cnt + 1;

  int bcnt, wcnt, clr_exp, rd_exp;
  logic prev_stall, prev_done;
  logic [WIDTH-1:0]  prev_dat;
  logic [ADDR_W-1:0] prev_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt <= 0; wcnt <= 0; clr_exp <= 0; rd_exp <= 0;
      prev_stall <= 1'b0; prev_done <= 1'b0; prev_dat <= '0; prev_addr <= '0;
    end else begin
      if (prev_done) chk("done_width", bus.done, 0);
      prev_done <= bus.done;
      bcnt <= bus.busy ? bcnt + 1 : 0;
      wcnt <= bus.busy ? wcnt + int'(bus.ram_wen) : 0;
      if (ph == PH_CLEAR) begin
        if (bus.busy) begin
          chk("clr_wen", bus.ram_wen, 1);
          chk("clr_din", bus.ram_din_a, 0);
          chk("clr_addr", bus.ram_addr_a, clr_exp);
          clr_exp <= clr_exp + 1;
        end else begin
          if (bus.done) begin
            chk("clr_cycles", bcnt, DEPTH);
            chk("clr_writes", wcnt, DEPTH);
          end
          clr_exp <= 0;
        end
      end
      if (ph == PH_READ) begin
        if (bus.busy) begin
          chk("rd_wen", bus.ram_wen, 0);
          if (prev_stall) begin
            chk("hold_vld", bus.rd_valid, 1);
            chk("hold_dat", bus.rd_data, prev_dat);
            chk("hold_addr", bus.rd_addr, prev_addr);
          end
          if (bus.rd_valid && bus.rd_ready) begin
            chk("rd_addr", bus.rd_addr, rd_exp % DEPTH);
            chk("rd_data", bus.rd_data, exp_bin[rd_exp % DEPTH]);
            rd_exp <= rd_exp + 1;
          end
        end else begin
          if (bus.done) chk("rd_words", rd_exp, DEPTH);
          rd_exp <= 0;
        end
      end
      prev_stall <= bus.rd_valid && !bus.rd_ready;
      prev_dat   <= bus.rd_data;
      prev_addr  <= bus.rd_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, input int d0, input int limit);
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      step();
      n++;
    end
    chk({nm, "_done"}, done_cnt - d0, 1);
  endtask

  task automatic chk_bins(input string nm);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (int'(mem[i]) != exp_bin[i]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic do_clear();
    int d0 = done_cnt;
    ph = PH_CLEAR;
    bus.start_clear = 1'b1; bus.start_acq = 1'b1; bus.start_read = 1'b1;
    step();
    bus.start_clear = 1'b0; bus.start_acq = 1'b0; bus.start_read = 1'b0;
    repeat (5) step();
    bus.start_acq = 1'b1;
    step();
    bus.start_acq = 1'b0;
    wait_done("clear", d0, DEPTH + 20);
    ph = PH_IDLE;
    for (int i = 0; i < DEPTH; i++) exp_bin[i] = 0;
    chk_bins("clear_bins");
  endtask

  task automatic do_read(input bit rnd, input string nm);
    int d0 = done_cnt;
    int gaps = 0;
    int n = 0;
    bit started = 1'b0;
    ph = PH_READ;
    bus.rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.start_read = 1'b1;
    step();
    bus.start_read = 1'b0;
    while (done_cnt == d0 && n < 8 * DEPTH + 20) begin
      if (rnd) bus.rd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!rnd && !bus.done) begin
        if (bus.rd_valid) started = 1'b1;
        else if (started) gaps++;
      end
      step();
      n++;
    end
    chk({nm, "_done"}, done_cnt - d0, 1);
    if (!rnd) chk({nm, "_gaps"}, gaps, 0);
    ph = PH_IDLE;
    bus.rd_ready = 1'b0;
  endtask

  task automatic run_acq(input string nm, input int num, input int stop_at);
    int d0 = done_cnt;
    int acc = 0;
    bit on = 1'b1;
    ph = PH_ACQ;
    bus.num_samples = 32'(num);
    bus.start_acq = 1'b1;
    step();
    bus.start_acq = 1'b0;
    bus.num_samples = $urandom;
    for (int i = 0; i < qv.size(); i++) begin
      bus.sample_valid = qv[i];
      bus.sample_code  = ADDR_W'(qc[i]);
      bus.stop_acq     = (i == stop_at);
      bus.start_clear  = (i == 1);
      if (on) begin
        if (i == stop_at) on = 1'b0;
        else if (qv[i]) begin
          exp_bin[qc[i]] = incb(exp_bin[qc[i]]);
          acc++;
          if (num != 0 && acc == num) on = 1'b0;
        end
      end
      step();
    end
    bus.sample_valid = 1'b0; bus.stop_acq = 1'b0; bus.start_clear = 1'b0;
    wait_done(nm, d0, 50);
    ph = PH_IDLE;
    chk_bins({nm, "_bins"});
    qv.delete();
    qc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_clear = 1'b0; bus.start_acq = 1'b0; bus.stop_acq = 1'b0; bus.start_read = 1'b0;
    bus.num_samples = '0; bus.sample_valid = 1'b0; bus.sample_code = '0; bus.rd_ready = 1'b0;
    repeat (3) step();
    scramble = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_wen", bus.ram_wen, 0);
    chk("rst_addr_a", bus.ram_addr_a, 0);
    chk("rst_addr_b", bus.ram_addr_b, 0);
    chk("rst_din", bus.ram_din_a, 0);
    step();
    rst_n = 1'b1;
    step();

    do_clear();
    do_read(1'b0, "read_zero");

    do_clear();
    for (int k = 0; k < 10 * DEPTH + 20; k++) begin
      qv.push_back(1'b1); qc.push_back(k % DEPTH);
      repeat (9) begin qv.push_back(1'b0); qc.push_back($urandom_range(0, DEPTH - 1)); end
    end
    run_acq("ramp", 10 * DEPTH, -1);
    chk("ramp_bin0", exp_bin[0], 10);
    chk("ramp_binlast", exp_bin[DEPTH - 1], 10);
    do_read(1'b1, "read_ramp");

    do_clear();
    for (int k = 0; k < 104; k++) begin qv.push_back(1'b1); qc.push_back(5); end
    run_acq("code5", 0, 100);
    chk("code5_bin5", exp_bin[5], 100);
    chk("code5_bin4", exp_bin[4], 0);
    do_read(1'b0, "read_code5");

    do_clear();
    foreach (qc[i]) qc[i] = 0;
    qv = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
    qc = '{7, 7, 8, 7, 8, 8, 0, 7, 8};
    run_acq("pair", 0, 7);
    chk("pair_bin7", exp_bin[7], 3);
    chk("pair_bin8", exp_bin[8], 3);

    do_clear();
    for (int k = 0; k < 400; k++) begin
      qv.push_back($urandom_range(0, 9) < 7);
      qc.push_back($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1));
    end
    qv[399] = 1'b1;
    run_acq("rand_stop", 0, 399);
    for (int k = 0; k < 400; k++) begin
      qv.push_back($urandom_range(0, 9) < 7);
      qc.push_back($urandom_range(0, 2));
    end
    run_acq("rand_num", $urandom_range(50, 150), 399);
    do_read(1'b1, "read_rand");

    do_clear();
    for (int k = 0; k < MAXV + 6; k++) begin qv.push_back(1'b1); qc.push_back(3); end
    run_acq("sat", MAXV + 2, -1);
`ifdef HIST_SATURATE_EN
    chk("sat_bin3", exp_bin[3], 255);
`else
    chk("sat_bin3", exp_bin[3], 1);
`endif
    do_read(1'b1, "read_sat");

    ph = PH_READ;
    bus.rd_ready = 1'b1;
    bus.start_read = 1'b1;
    step();
    bus.start_read = 1'b0;
    repeat (20) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("abort_rd_valid", bus.rd_valid, 0);
    chk("abort_busy", bus.busy, 0);
    ph = PH_IDLE;
    bus.rd_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    do_clear();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
